obuf_tx: RTL and testbench
==========================

Name: obuf_tx

Overview:
- Sits downstream of the eJ32 core on the 8-bit memory bus.
- Snoops core byte writes that land in the output buffer window starting at OBUF.
- Queues those bytes in a small FIFO and drains them through a valid/ready byte stream, e.g. to a UART TX or a bench console.
- Also checks that output bytes are written at sequential addresses and flags overflow and sequence errors.

Parameters:
- OBUF, 'h1400: base byte address of the output buffer window.
- OBSZ, 'h400: window size in bytes; must be a power of two.
- ASZ, 17: address width; matches the core's 128K space.
- DEPTH, 16: FIFO depth in bytes; must be a power of two, at least 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr_i  in  1  synchronous flush; clears FIFO, flags and the expected address.
- write_i  in  1  core memory write strobe.
- addr_i  in  ASZ  core memory byte address.
- data_i  in  8  core write data.
- tx_valid_o  out  1  output byte available.
- tx_data_o  out  8  output byte.
- tx_ready_i  in  1  consumer accepts the byte.
- level_o  out  $clog2(DEPTH)+1  bytes held, including the byte on tx_data_o.
- ovf_o  out  1  sticky: a byte was dropped because the FIFO was full.
- seq_err_o  out  1  sticky: a write was not at the expected sequential address.

Behaviour:
- Reset (rst_n=0, asynchronous): tx_valid_o=0, tx_data_o=0, level_o=0, ovf_o=0, seq_err_o=0, read and write pointers=0, exp_addr=OBUF. Reset takes effect immediately, mid-transfer included. Queued bytes are discarded.
- clr_i=1 at an edge: same state as reset, applied synchronously. clr_i has priority over a capture or pop in the same cycle.
- Capture condition: write_i=1 and OBUF <= addr_i < OBUF+OBSZ.
  - Evaluated every cycle; one byte is captured per qualifying cycle.
  - The core asserts write_i for exactly one cycle per byte.
  - Writes outside the window are ignored entirely: no flag change, exp_addr unchanged.
- Sequence check on capture:
  - If addr_i != exp_addr, set seq_err_o. The byte is still queued.
  - exp_addr <= addr_i+1. When addr_i+1 = OBUF+OBSZ, exp_addr wraps to OBUF.
- Pop: occurs at an edge where tx_valid_o=1 and tx_ready_i=1.
- FIFO storage: DEPTH-entry circular buffer. Pointers are $clog2(DEPTH)+1 bits; full/empty are decided by the extra MSB.
- Output is registered: tx_data_o and tx_valid_o come from a head register, not combinationally from storage.
- Latency: when the block is empty, a byte captured at edge N gives tx_valid_o=1 with that byte after edge N. It is visible in cycle N+1 and can be popped at edge N+1.
- Handshake: tx_data_o is held stable while tx_valid_o=1 and tx_ready_i=0. tx_valid_o never drops without a pop, clr_i or reset.
- Back-to-back drain: with tx_ready_i held high and the FIFO non-empty, one byte is delivered per cycle with no bubble.
- Capacity: level_o ranges 0..DEPTH. Full means level_o=DEPTH.
- Capture while full with no pop in the same cycle: byte dropped, ovf_o set, level unchanged. seq_err_o and exp_addr still update.
- Capture while full with a pop in the same cycle: accepted, level unchanged, no overflow.
- Capture and pop in the same cycle at any level: level unchanged; FIFO order is preserved.
- Empty with a pop: impossible, since tx_valid_o=0.
- level_o update: +1 on capture-only, -1 on pop-only, unchanged on both or neither.
- Sticky flags clear only on reset or clr_i.

Test Plan:
- Reset, then core writes 'h41,'h42,'h43 to 'h1400..'h1402 on three consecutive cycles with tx_ready_i=1. Required: tx_data_o shows 41,42,43 in cycles N+1..N+3; level_o peaks at 1; seq_err_o=0.
- tx_ready_i=0, write 16 bytes 'h00..'h0F at 'h1400.. then a 17th byte 'hFF. Required: level_o=16, ovf_o=1. Raising tx_ready_i drains exactly 00..0F, then tx_valid_o=0.
- Full FIFO; write 'h55 in the same cycle tx_ready_i=1. Required: byte accepted, ovf_o stays 0, 'h55 emerges last.
- Writes to 'h1400 then 'h1405. Required: seq_err_o=1 and both bytes delivered. A write to 'h13FF or 'h1800 produces nothing and leaves exp_addr unchanged.
- Writes to 'h17FF then 'h1400. Required: wrap, seq_err_o remains 0.
- Queue 5 bytes, assert rst_n=0 asynchronously mid-drain, release. Required: tx_valid_o=0 and level_o=0 immediately. The next write to 'h1400 is delivered with no seq_err_o. Repeat the check using clr_i.

Source files
------------

// File: rtl/obuf_tx.sv
// obuf_tx: snoops core byte writes into the output buffer window, queues them
// in a small FIFO and drains them over a registered valid/ready byte stream.
// Sticky flags report dropped bytes (FIFO full) and non-sequential writes.
module obuf_tx #(
    parameter int unsigned OBUF  = 'h1400,
    parameter int unsigned OBSZ  = 'h400,
    parameter int unsigned ASZ   = 17,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr_i,
    input  logic                       write_i,
    input  logic [ASZ-1:0]             addr_i,
    input  logic [7:0]                 data_i,
    output logic                       tx_valid_o,
    output logic [7:0]                 tx_data_o,
    input  logic                       tx_ready_i,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       ovf_o,
    output logic                       seq_err_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    // Window bounds carry one spare bit so OBUF+OBSZ never overflows.
    localparam logic [ASZ:0]   WIN_LO  = (ASZ+1)'(OBUF);
    localparam logic [ASZ:0]   WIN_HI  = (ASZ+1)'(OBUF + OBSZ);
    localparam logic [ASZ-1:0] EXP_RST = ASZ'(OBUF);
    localparam logic [PW-1:0]  LVL_FULL = PW'(DEPTH);

    // True when the byte address falls inside [OBUF, OBUF+OBSZ).
    function automatic logic in_window(input logic [ASZ-1:0] a);
        logic [ASZ:0] ax;
        ax = {1'b0, a};
        return (ax >= WIN_LO) && (ax < WIN_HI);
    endfunction

    // Address the next sequential write should use; wraps at the window top.
    function automatic logic [ASZ-1:0] next_exp(input logic [ASZ-1:0] a);
        logic [ASZ:0] nx;
        nx = {1'b0, a} + (ASZ+1)'(1);
        if (nx == WIN_HI) begin
            return EXP_RST;
        end
        return nx[ASZ-1:0];
    endfunction

    // Storage and pointers; the extra pointer MSB separates full from empty.
    logic [7:0]      mem [DEPTH];
    logic [PW-1:0]   wr_ptr, wr_ptr_n;
    logic [PW-1:0]   rd_ptr, rd_ptr_n;
    logic [ASZ-1:0]  exp_addr, exp_addr_n;
    logic            ovf, ovf_n;
    logic            seq_err, seq_err_n;

    // Output head register: always a copy of the entry at rd_ptr.
    logic [7:0]      head_data_p1, head_data_n;
    logic            vld_p1, vld_n;

    logic            cap;
    logic            pop;
    logic            push;
    logic            drop;
    logic            full;
    logic [PW-1:0]   level;

    assign cap   = write_i && in_window(addr_i);
    assign level = wr_ptr - rd_ptr;
    assign full  = (level == LVL_FULL);
    assign pop   = vld_p1 && tx_ready_i;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push  = cap && (!full || pop);
    assign drop  = cap && full && !pop;

    // Next-state: pointers, sequence tracking, flags and the head prefetch.
    always_comb begin
        wr_ptr_n    = wr_ptr;
        rd_ptr_n    = rd_ptr;
        exp_addr_n  = exp_addr;
        ovf_n       = ovf;
        seq_err_n   = seq_err;
        vld_n       = vld_p1;
        head_data_n = head_data_p1;
        if (clr_i) begin
            wr_ptr_n    = '0;
            rd_ptr_n    = '0;
            exp_addr_n  = EXP_RST;
            ovf_n       = 1'b0;
            seq_err_n   = 1'b0;
            vld_n       = 1'b0;
            head_data_n = '0;
        end else begin
            if (push) begin
                wr_ptr_n = wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr_n = rd_ptr + PW'(1);
            end
            if (cap) begin
                exp_addr_n = next_exp(addr_i);
                if (addr_i != exp_addr) begin
                    seq_err_n = 1'b1;
                end
            end
            if (drop) begin
                ovf_n = 1'b1;
            end
            vld_n = (wr_ptr_n != rd_ptr_n);
            // When the new head is the byte being written this cycle it is
            // not in storage yet, so it is taken straight from the bus.
            if (vld_n) begin
                if (push && (wr_ptr == rd_ptr_n)) begin
                    head_data_n = data_i;
                end else begin
                    head_data_n = mem[rd_ptr_n[AW-1:0]];
                end
            end
        end
    end

    // Storage write; holds data only, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push && !clr_i) begin
            mem[wr_ptr[AW-1:0]] <= data_i;
        end
    end

    // Control and head state register with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            exp_addr     <= EXP_RST;
            ovf          <= 1'b0;
            seq_err      <= 1'b0;
            vld_p1       <= 1'b0;
            head_data_p1 <= '0;
        end else begin
            wr_ptr       <= wr_ptr_n;
            rd_ptr       <= rd_ptr_n;
            exp_addr     <= exp_addr_n;
            ovf          <= ovf_n;
            seq_err      <= seq_err_n;
            vld_p1       <= vld_n;
            head_data_p1 <= head_data_n;
        end
    end

    assign tx_valid_o = vld_p1;
    assign tx_data_o  = head_data_p1;
    assign level_o    = level;
    assign ovf_o      = ovf;
    assign seq_err_o  = seq_err;

endmodule

// File: tb/tb_obuf_tx.sv
// tb_obuf_tx: directed bench for obuf_tx with hand-computed expectations.
module tb_obuf_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr_i;
    logic        write_i;
    logic [16:0] addr_i;
    logic [7:0]  data_i;
    logic        tx_valid_o;
    logic [7:0]  tx_data_o;
    logic        tx_ready_i;
    logic [4:0]  level_o;
    logic        ovf_o;
    logic        seq_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    obuf_tx #(
        .OBUF (17'h1400),
        .OBSZ (17'h400),
        .ASZ  (17),
        .DEPTH(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (clr_i),
        .write_i   (write_i),
        .addr_i    (addr_i),
        .data_i    (data_i),
        .tx_valid_o(tx_valid_o),
        .tx_data_o (tx_data_o),
        .tx_ready_i(tx_ready_i),
        .level_o   (level_o),
        .ovf_o     (ovf_o),
        .seq_err_o (seq_err_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle core write strobe.
    task automatic wr(input logic [16:0] a, input logic [7:0] d);
        write_i = 1'b1;
        addr_i  = a;
        data_i  = d;
        tick();
        write_i = 1'b0;
    endtask

    task automatic clear();
        clr_i = 1'b1;
        tick();
        clr_i = 1'b0;
    endtask

    initial begin
        rst_n      = 1'b0;
        clr_i      = 1'b0;
        write_i    = 1'b0;
        addr_i     = '0;
        data_i     = '0;
        tx_ready_i = 1'b0;
        tick();
        tick();
        check("rst_valid", tx_valid_o, 0);
        check("rst_data", tx_data_o, 0);
        check("rst_level", level_o, 0);
        check("rst_ovf", ovf_o, 0);
        check("rst_seq", seq_err_o, 0);
        rst_n = 1'b1;
        tick();

        // Three consecutive writes streaming straight through.
        tx_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr(17'h1400 + 17'(i), 8'h41 + 8'(i));
            check("stream_valid", tx_valid_o, 1);
            check("stream_data", tx_data_o, 32'h41 + 32'(i));
            check("stream_level", level_o, 1);
        end
        tick();
        check("stream_empty", tx_valid_o, 0);
        check("stream_level0", level_o, 0);
        check("stream_seq", seq_err_o, 0);

        // Fill to capacity, overflow on the 17th byte, then drain.
        clear();
        tx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(17'h1400 + 17'(i), 8'(i));
        end
        check("fill_level", level_o, 16);
        check("fill_ovf0", ovf_o, 0);
        wr(17'h1410, 8'hFF);
        check("ovf_level", level_o, 16);
        check("ovf_flag", ovf_o, 1);
        check("ovf_head", tx_data_o, 8'h00);
        check("ovf_seq", seq_err_o, 0);
        tx_ready_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("drain_valid", tx_valid_o, 1);
            check("drain_data", tx_data_o, 32'(i));
            tick();
        end
        check("drain_done", tx_valid_o, 0);
        check("drain_level", level_o, 0);
        check("ovf_sticky", ovf_o, 1);

        // Full FIFO with a simultaneous pop accepts the new byte.
        clear();
        check("clr_ovf", ovf_o, 0);
        tx_ready_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            wr(17'h1400 + 17'(i), 8'h10 + 8'(i));
        end
        check("full2_level", level_o, 16);
        tx_ready_i = 1'b1;
        wr(17'h1410, 8'h55);
        check("fullpop_level", level_o, 16);
        check("fullpop_ovf", ovf_o, 0);
        check("fullpop_head", tx_data_o, 8'h11);
        for (int i = 1; i < 16; i++) begin
            check("fullpop_data", tx_data_o, 32'h10 + 32'(i));
            tick();
        end
        check("fullpop_last", tx_data_o, 8'h55);
        check("fullpop_lastv", tx_valid_o, 1);
        tick();
        check("fullpop_empty", tx_valid_o, 0);

        // Address jump flags a sequence error; both bytes still delivered.
        clear();
        tx_ready_i = 1'b0;
        wr(17'h1400, 8'hA0);
        check("seq_ok", seq_err_o, 0);
        wr(17'h1405, 8'hA5);
        check("seq_err", seq_err_o, 1);
        check("seq_level", level_o, 2);
        tx_ready_i = 1'b1;
        check("seq_d0", tx_data_o, 8'hA0);
        tick();
        check("seq_d1", tx_data_o, 8'hA5);
        tick();
        check("seq_empty", tx_valid_o, 0);

        // Writes just outside the window are ignored and leave exp_addr alone.
        clear();
        tx_ready_i = 1'b0;
        wr(17'h1400, 8'hB0);
        wr(17'h13FF, 8'hC0);
        check("below_level", level_o, 1);
        wr(17'h1800, 8'hC1);
        check("above_level", level_o, 1);
        check("outside_seq", seq_err_o, 0);
        wr(17'h1401, 8'hB1);
        check("after_out_level", level_o, 2);
        check("after_out_seq", seq_err_o, 0);
        check("after_out_head", tx_data_o, 8'hB0);

        // Walk the whole window; the write after 17FF wraps to 1400 cleanly.
        clear();
        tx_ready_i = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            wr(17'h1400 + 17'(i), 8'(i));
        end
        check("top_data", tx_data_o, 8'hFF);
        check("top_seq", seq_err_o, 0);
        wr(17'h1400, 8'h77);
        check("wrap_data", tx_data_o, 8'h77);
        check("wrap_seq", seq_err_o, 0);
        tick();

        // Asynchronous reset mid-drain, with flags set beforehand.
        clear();
        tx_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr(17'h1400 + 17'(i), 8'h60 + 8'(i));
        end
        wr(17'h1410, 8'h64);
        check("pre_rst_level", level_o, 5);
        check("pre_rst_seq", seq_err_o, 1);
        tx_ready_i = 1'b1;
        tick();
        tick();
        check("mid_level", level_o, 3);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", tx_valid_o, 0);
        check("arst_level", level_o, 0);
        check("arst_seq", seq_err_o, 0);
        check("arst_data", tx_data_o, 0);
        #2;
        rst_n = 1'b1;
        wr(17'h1400, 8'h99);
        check("post_rst_valid", tx_valid_o, 1);
        check("post_rst_data", tx_data_o, 8'h99);
        check("post_rst_seq", seq_err_o, 0);
        tick();

        // Same recovery through clr_i, which also beats a concurrent write.
        tx_ready_i = 1'b0;
        for (int i = 1; i < 5; i++) begin
            wr(17'h1400 + 17'(i), 8'h80 + 8'(i));
        end
        wr(17'h1420, 8'h85);
        check("pre_clr_level", level_o, 5);
        check("pre_clr_seq", seq_err_o, 1);
        tx_ready_i = 1'b1;
        tick();
        clr_i   = 1'b1;
        write_i = 1'b1;
        addr_i  = 17'h1400;
        data_i  = 8'hEE;
        tick();
        clr_i   = 1'b0;
        write_i = 1'b0;
        check("clr_valid", tx_valid_o, 0);
        check("clr_level", level_o, 0);
        check("clr_seq", seq_err_o, 0);
        wr(17'h1400, 8'h98);
        check("post_clr_data", tx_data_o, 8'h98);
        check("post_clr_valid", tx_valid_o, 1);
        check("post_clr_seq", seq_err_o, 0);
        tick();
        check("final_empty", tx_valid_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
